// File: rtl/core_pkg.sv
// core_pkg: core-wide constants shared by the fetch front end.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(1);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: data-only FIFO with flush; pointers wrap by natural overflow.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !flush_i) assert (cnt_q != (AW+1)'(DEPTH));
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetch with request/response memory,
// prefetch FIFO and redirect flush that drops stale in-flight responses.
module fetch_unit #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(core_pkg::PC_STEP),
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus,
  input  logic            instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
  logic [CW:0] used;
  logic accept, rsp_ok, push, pop;
  assign used           = {1'b0, count} + {1'b0, out_q};
  assign imem_req_valid = rst && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (out_q != '0);
  assign push           = rsp_ok && (disc_q == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid    = (count != '0);
  assign instr_pc       = head_pc_q;
  assign instr_pc_plus  = head_pc_q + PC_STEP;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (imem_rsp_data),
    .data_o  (instr),
    .count_o (count)
  );
  // A redirect turns every still-unanswered request into a response to drop.
  always_comb begin
    out_d      = out_q + CW'(accept) - CW'(rsp_ok);
    disc_d     = redirect_valid ? out_q - CW'(rsp_ok) : disc_q - CW'(rsp_ok && disc_q != '0);
    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q + (accept ? PC_STEP : '0);
    head_pc_d  = redirect_valid ? redirect_pc : head_pc_q + (pop ? PC_STEP : '0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && imem_rsp_valid) assert (out_q != '0);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against an in-order memory model
// and an expected-instruction scoreboard.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, redirect_valid = 0, imem_req_ready = 0;
  logic imem_rsp_valid = 0, instr_ready = 0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instr, instr_pc, instr_pc_plus;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus(instr_pc_plus), .instr_ready(instr_ready)
  );

  typedef struct {logic [31:0] addr; int due;} ent_t;
  ent_t mem_q[$];
  logic [31:0] sb[$];
  int checks = 0, errors = 0, cyc = 0, lat = 1, stale = 0, dut_del = 0, d0;
  logic [31:0] exp_addr = '0, prev_addr = '0;
  bit prev_pend = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit m_req, m_valid, deq, rsp;
    ent_t e;
    #1;
    m_valid = sb.size() != 0;
    m_req   = !redirect_valid && (sb.size() + mem_q.size() < DEPTH);
    chk("instr_valid", instr_valid, m_valid);
    chk("req_valid", imem_req_valid, m_req);
    if (m_req) chk("req_addr", imem_req_addr, exp_addr);
    if (prev_pend && !redirect_valid) begin
      chk("req_hold", imem_req_valid, 1);
      chk("addr_hold", imem_req_addr, prev_addr);
    end
    deq = m_valid && instr_ready && !redirect_valid;
    if (deq) begin
      chk("instr", instr, dat(sb[0]));
      chk("instr_pc", instr_pc, sb[0]);
      chk("instr_pc_plus", instr_pc_plus, sb[0] + 32'd1);
    end
    if (instr_valid && instr_ready && !redirect_valid) dut_del++;
    rsp       = imem_rsp_valid;
    prev_pend = m_req && !imem_req_ready;
    prev_addr = exp_addr;
    @(posedge clk);
    cyc++;
    if (deq) void'(sb.pop_front());
    if (rsp) begin
      e = mem_q.pop_front();
      if (stale > 0) stale--;
      else if (!redirect_valid) sb.push_back(e.addr);
    end
    if (m_req && imem_req_ready) begin
      e.addr = exp_addr;
      e.due  = cyc + lat - 1;
      mem_q.push_back(e);
      exp_addr += 32'd1;
    end
    if (redirect_valid) begin
      sb.delete();
      stale    = mem_q.size();
      exp_addr = redirect_pc;
    end
    @(negedge clk);
    imem_rsp_valid = mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rsp_data  = imem_rsp_valid ? dat(mem_q[0].addr) : '0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    imem_req_ready = 1;
    instr_ready    = 1;
    #3;
    chk("reset_instr_valid", instr_valid, 0);
    chk("reset_req_valid", imem_req_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    run(5);
    d0 = dut_del;
    run(10);
    chk("throughput", dut_del - d0, 10);

    instr_ready = 0;
    run(10);
    #1;
    chk("full_req_low", imem_req_valid, 0);
    chk("full_instr_valid", instr_valid, 1);
    instr_ready = 1;
    run(8);

    lat = 3;
    run(8);
    redirect(32'h40);
    run(15);

    lat = 1;
    run(6);
    #1;
    chk("pre_redirect_valid", instr_valid, 1);
    chk("pre_redirect_rsp", {31'd0, imem_rsp_valid}, 1);
    redirect(32'h200);
    run(8);

    imem_req_ready = 0;
    run(5);
    imem_req_ready = 1;
    run(8);

    redirect(32'hFFFF_FFFE);
    run(8);

    repeat (300) begin
      imem_req_ready = $urandom_range(0, 3) != 0;
      instr_ready    = $urandom_range(0, 3) != 0;
      lat            = $urandom_range(1, 3);
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 0;
    imem_req_ready = 1;
    instr_ready    = 1;
    lat            = 1;
    run(8);

    #1;
    chk("pre_reset_valid", instr_valid, 1);
    #1;
    rst = 0;
    #1;
    chk("async_instr_valid", instr_valid, 0);
    chk("async_req_valid", imem_req_valid, 0);
    mem_q.delete();
    sb.delete();
    stale          = 0;
    exp_addr       = '0;
    prev_pend      = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
